// File: rtl/sequential_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with div_by_zero set.
module sequential_divider #(
   parameter int WORD_LENGTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] Dividend,
   input  logic [WORD_LENGTH-1:0] Divisor,
   output logic                   busy,
   output logic                   ready,
   output logic [WORD_LENGTH-1:0] Quotient,
   output logic [WORD_LENGTH-1:0] Remainder,
   output logic                   div_by_zero
);

   localparam int W  = WORD_LENGTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W:0]      prem_q, prem_d;
   logic [W-1:0]    dvd_q, dvd_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;
   logic [W-1:0]    quotient_q, quotient_d;
   logic [W-1:0]    remainder_q, remainder_d;

   logic [W:0]      rem_shift;
   logic [W:0]      rem_next;
   logic [W-1:0]    quo_next;
   logic            fits;

   function automatic logic [W-1:0] mag(input logic [W-1:0] x);
      return x[W-1] ? (~x + 1'b1) : x;
   endfunction

`ifdef DIV_ZERO_DETECT_EN
   logic dbz_q, dbz_d;
`endif

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      prem_d      = prem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      busy_d      = busy_q;
      ready_d     = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
      dbz_d       = dbz_q;
`endif

      // The bit shifted out of the partial remainder means the trial always fits.
      rem_shift = {prem_q[W-1:0], dvd_q[W-1]};
      fits      = prem_q[W] || (rem_shift >= {1'b0, dvs_q});
      rem_next  = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
      quo_next  = {dvd_q[W-2:0], fits};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            dvd_d   = mag(Dividend);
            dvs_d   = mag(Divisor);
            q_neg_d = Dividend[W-1] ^ Divisor[W-1];
            r_neg_d = Dividend[W-1];
            prem_d  = '0;
            cnt_d   = '0;
            state_d = DIVIDE;
`ifdef DIV_ZERO_DETECT_EN
            dbz_d   = 1'b0;
            if (Divisor == '0) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               ready_d     = 1'b1;
               quotient_d  = '1;
               remainder_d = Dividend;
               dbz_d       = 1'b1;
            end
`endif
         end
         DIVIDE: begin
            prem_d = rem_next;
            dvd_d  = quo_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               ready_d     = 1'b1;
               quotient_d  = q_neg_q ? (~quo_next + 1'b1) : quo_next;
               remainder_d = r_neg_q ? (~rem_next[W-1:0] + 1'b1) : rem_next[W-1:0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prem_q      <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q       <= dbz_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign ready     = ready_q;
   assign Quotient  = quotient_q;
   assign Remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WORD_LENGTH=8): vector table, random model vectors,
// and hand sequences for ignored start, mid-divide reset and zero divisor.
module tb_sequential_divider;

   localparam int W = 8;

`ifdef DIV_ZERO_DETECT_EN
   localparam logic ZERO_DBZ = 1'b1;
   localparam int   ZERO_LAT = 1;
`else
   localparam logic ZERO_DBZ = 1'b0;
   localparam int   ZERO_LAT = W + 1;
`endif

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
      int           launch;
      string        name;
   } op_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  ready_cnt = 0;
   op_t sb[$];
   op_t tbl[$];

   sequential_divider #(.WORD_LENGTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .Dividend   (dividend),
      .Divisor    (divisor),
      .busy       (busy),
      .ready      (ready),
      .Quotient   (quotient),
      .Remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic op_t model(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      op_t o;
      int  ia;
      int  ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      o.dvd = a;
      o.dvs = b;
      o.name = name;
      o.launch = 0;
      if (b == '0) begin
`ifdef DIV_ZERO_DETECT_EN
         o.q = '1;
`else
         o.q = a[W-1] ? 8'h01 : 8'hFF;
`endif
         o.r   = a;
         o.dbz = ZERO_DBZ;
         o.lat = ZERO_LAT;
      end else begin
         o.q   = 8'(ia / ib);
         o.r   = 8'(ia % ib);
         o.dbz = 1'b0;
         o.lat = W + 1;
      end
      return o;
   endfunction

   // Scoreboard consumer: every ready pulse must match the oldest outstanding operation.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         ready_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_ready", 32'(ready), 32'd0);
         end else begin
            op_t e;
            e = sb.pop_front();
            check({e.name, "_quotient"},  32'(quotient),    32'(e.q));
            check({e.name, "_remainder"}, 32'(remainder),   32'(e.r));
            check({e.name, "_dbz"},       32'(div_by_zero), 32'(e.dbz));
            check({e.name, "_latency"},   32'(cyc - e.launch), 32'(e.lat));
            check({e.name, "_busy_at_ready"}, 32'(busy), 32'd0);
         end
      end
   end

   task automatic launch(input op_t o);
      @(negedge clk);
      dividend = o.dvd;
      divisor  = o.dvs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      o.launch = cyc;
      sb.push_back(o);
      check({o.name, "_busy_in_load"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
      end
      if (sb.size() != 0) begin
         check("timeout_pending_ops", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      op_t o;
      int  rc0;

      tbl.push_back('{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, W + 1, 0, "p100_p7"});
      tbl.push_back('{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, W + 1, 0, "m100_p7"});
      tbl.push_back('{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, W + 1, 0, "p100_m7"});
      tbl.push_back('{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, W + 1, 0, "m100_m7"});
      tbl.push_back('{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, W + 1, 0, "m128_m1"});
      tbl.push_back('{8'h80,  8'd3,   8'hD6, 8'hFE, 1'b0, W + 1, 0, "m128_p3"});
      tbl.push_back('{8'd127, 8'd1,   8'h7F, 8'h00, 1'b0, W + 1, 0, "p127_p1"});
      tbl.push_back('{8'd1,   8'h80,  8'h00, 8'h01, 1'b0, W + 1, 0, "p1_m128"});
      tbl.push_back('{8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0, W + 1, 0, "m1_p2"});
      tbl.push_back('{8'd7,   8'd7,   8'h01, 8'h00, 1'b0, W + 1, 0, "p7_p7"});
      tbl.push_back('{8'd50,  8'd0,   8'hFF, 8'h32, ZERO_DBZ, ZERO_LAT, 0, "p50_zero"});

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",      32'(busy),        32'd0);
      check("reset_ready",     32'(ready),       32'd0);
      check("reset_quotient",  32'(quotient),    32'd0);
      check("reset_remainder", 32'(remainder),   32'd0);
      check("reset_dbz",       32'(div_by_zero), 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         launch(tbl[i]);
         wait_done();
      end

      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = W'($urandom);
         launch(model(a, b, $sformatf("rand%0d", i)));
         wait_done();
      end

      // start re-pulsed with new operands while DIVIDE is running must be ignored.
      rc0 = ready_cnt;
      launch(model(8'd100, 8'd7, "ignored_start"));
      repeat (3) @(posedge clk);
      #1;
      dividend = 8'h11;
      divisor  = 8'h02;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      repeat (3) @(posedge clk);
      #1;
      check("ignored_start_ready_pulses", 32'(ready_cnt - rc0), 32'd1);

      // Reset asserted during the 4th DIVIDE cycle abandons the operation.
      launch(model(8'h9C, 8'd7, "aborted"));
      repeat (4) @(posedge clk);
      #1;
      check("abort_busy_mid_divide", 32'(busy), 32'd1);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check("abort_busy",      32'(busy),        32'd0);
      check("abort_ready",     32'(ready),       32'd0);
      check("abort_quotient",  32'(quotient),    32'd0);
      check("abort_remainder", 32'(remainder),   32'd0);
      check("abort_dbz",       32'(div_by_zero), 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_idle_busy", 32'(busy), 32'd0);
      launch('{8'd9, 8'd3, 8'h03, 8'h00, 1'b0, W + 1, 0, "after_abort_9_3"});
      wait_done();

      // A zero divisor with a negative dividend, then a normal divide to clear the flag.
      launch(model(8'hF6, 8'd0, "m10_zero"));
      wait_done();
      launch(model(8'd20, 8'd6, "after_zero"));
      wait_done();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
